// File: rtl/fme_cost_cmp_pkg.sv
// Shared definitions for the FME cost-compare / MV-refine stage.
// Contents:
//   - widths of MV components, candidate SATD and total cost
//   - FSM state encoding
//   - candidate offset table (index 0..8 -> {dx,dy}) and its L1 magnitude
package fme_cost_cmp_pkg;

  localparam int FMV_WIDTH  = 10;
  localparam int SATD_WIDTH = 16;
  localparam int COST_WIDTH = 20;
  localparam int NUM_CAND   = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Unit offset of one candidate, each component in {-1,0,+1}
  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } offset_t;

  // Candidate 0 is the centre; 1..8 walk the 3x3 neighbourhood row by row
  function automatic offset_t cand_offset(input logic [3:0] idx);
    offset_t o;
    case (idx)
      4'd1:    o = {2'b11, 2'b11};
      4'd2:    o = {2'b00, 2'b11};
      4'd3:    o = {2'b01, 2'b11};
      4'd4:    o = {2'b11, 2'b00};
      4'd5:    o = {2'b01, 2'b00};
      4'd6:    o = {2'b11, 2'b01};
      4'd7:    o = {2'b00, 2'b01};
      4'd8:    o = {2'b01, 2'b01};
      default: o = {2'b00, 2'b00};
    endcase
    return o;
  endfunction

  // |dx| + |dy| for a unit offset: each non-zero component contributes 1
  function automatic logic [1:0] offset_mag(input offset_t o);
    return {1'b0, |o.dx} + {1'b0, |o.dy};
  endfunction

endpackage

// File: rtl/fme_mv_buf.sv
// 64-entry MV buffer, one synchronous write port and one synchronous read
// port. A read and a write of the same address in the same cycle returns
// the data held before the write. The array itself is never reset; only the
// read data register is.
// Ports:
//   clk    clock
//   rstn   synchronous active-high reset (clears rdata only)
//   we     write enable
//   waddr  write address
//   wdata  write data
//   re     read enable; rdata updates one cycle later, else holds
//   raddr  read address
//   rdata  registered read data
module fme_mv_buf #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Storage array: written only on an explicit write strobe
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register: samples the array before this cycle's write lands
  always_ff @(posedge clk) begin
    if (rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fme_cost_cmp.sv
// Cost-compare and MV-refine stage behind the FME SATD path. For each 8x8
// block it takes 9 candidate SATDs in index order, adds a lambda-weighted
// offset penalty, keeps the minimum (lower index wins ties) and writes the
// refined MV into an internal 64-entry buffer addressed by block index.
// Ports:
//   clk, rstn         clock, synchronous active-high reset
//   half_flag_i       1 = half-pel pass (step 2), 0 = quarter pass (step 1)
//   lambda_i          penalty weight, sampled with candidate 0
//   cost_valid_i      candidate valid
//   cost_ready_o      stage accepts a candidate this cycle
//   cand_i, satd_i    candidate index and its SATD
//   blk_idx_i         block index, sampled with candidate 0
//   base_mv_i         centre MV {x,y}, sampled with candidate 0
//   last_blk_i        last block of the pass, sampled with candidate 0
//   mv_rden_i         MV buffer read enable
//   mv_rdaddr_i       MV buffer read address
//   mv_data_o         MV buffer read data {x,y}, valid one cycle after rden
//   best_cost_o       winning cost of the most recently written block
//   cost_done_o       one-cycle pulse at end of pass
//   err_o             sticky protocol error
module fme_cost_cmp
  import fme_cost_cmp_pkg::*;
#(
  parameter int FMV_WIDTH  = fme_cost_cmp_pkg::FMV_WIDTH,
  parameter int SATD_WIDTH = fme_cost_cmp_pkg::SATD_WIDTH,
  parameter int COST_WIDTH = fme_cost_cmp_pkg::COST_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   half_flag_i,
  input  logic [7:0]             lambda_i,
  input  logic                   cost_valid_i,
  output logic                   cost_ready_o,
  input  logic [3:0]             cand_i,
  input  logic [SATD_WIDTH-1:0]  satd_i,
  input  logic [5:0]             blk_idx_i,
  input  logic [2*FMV_WIDTH-1:0] base_mv_i,
  input  logic                   last_blk_i,
  input  logic                   mv_rden_i,
  input  logic [5:0]             mv_rdaddr_i,
  output logic [2*FMV_WIDTH-1:0] mv_data_o,
  output logic [COST_WIDTH-1:0]  best_cost_o,
  output logic                   cost_done_o,
  output logic                   err_o
);

  state_t state_q, state_d;

  logic [5:0]             blk_q;
  logic [2*FMV_WIDTH-1:0] base_q;
  logic                   last_q;
  logic [7:0]             lambda_q;
  logic                   half_q;
  logic [COST_WIDTH-1:0]  min_q;
  logic [3:0]             best_q;
  logic [3:0]             expect_q;

  logic                   accept;
  logic [3:0]             expect_cand;
  logic                   cand_ok;
  logic                   match;
  logic [7:0]             lambda_eff;
  logic                   half_eff;
  offset_t                cur_off;
  logic [2:0]             pen_units;
  logic [10:0]            penalty;
  logic [COST_WIDTH-1:0]  cand_cost;

  offset_t                best_off;
  logic [FMV_WIDTH-1:0]   off_x, off_y;
  logic [FMV_WIDTH-1:0]   new_x, new_y;
  logic                   buf_we;

  // Candidate acceptance. Outside ACC the only legal index is 0, so a stray
  // index in IDLE is flagged the same way as an out-of-order one in ACC.
  // Candidate 0 uses the live lambda/step; the rest use the latched copies.
  always_comb begin
    accept      = cost_valid_i && cost_ready_o;
    expect_cand = (state_q == ST_ACC) ? expect_q : 4'd0;
    cand_ok     = (cand_i == expect_cand);
    match       = accept && cand_ok;
    lambda_eff  = (state_q == ST_IDLE) ? lambda_i : lambda_q;
    half_eff    = (state_q == ST_IDLE) ? half_flag_i : half_q;
    cur_off     = cand_offset(cand_i);
    pen_units   = {1'b0, offset_mag(cur_off)} << half_eff;
    penalty     = {3'b000, lambda_eff} * {8'h00, pen_units};
    cand_cost   = COST_WIDTH'(satd_i) + COST_WIDTH'(penalty);
  end

  // Refined MV: sign-extended winning offset, doubled in the half pass,
  // added per component with natural wrap at FMV_WIDTH
  always_comb begin
    best_off = cand_offset(best_q);
    off_x    = {{(FMV_WIDTH-2){best_off.dx[1]}}, best_off.dx};
    off_y    = {{(FMV_WIDTH-2){best_off.dy[1]}}, best_off.dy};
    if (half_q) begin
      off_x = off_x << 1;
      off_y = off_y << 1;
    end
    new_x  = base_q[2*FMV_WIDTH-1:FMV_WIDTH] + off_x;
    new_y  = base_q[FMV_WIDTH-1:0] + off_y;
    buf_we = (state_q == ST_WRITE) && !rstn;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: 9 accepted candidates, one write cycle, and an extra
  // DONE cycle only when the block closes the pass
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (match) state_d = ST_ACC;
      ST_ACC:   if (match && (cand_i == 4'd8)) state_d = ST_WRITE;
      ST_WRITE: state_d = last_q ? ST_DONE : ST_IDLE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; held low while reset is asserted
  always_comb begin
    cost_ready_o = !rstn && ((state_q == ST_IDLE) || (state_q == ST_ACC));
    cost_done_o  = !rstn && (state_q == ST_DONE);
  end

  // Block context, running minimum and error flag. Strict less-than keeps
  // the earlier candidate on a tie.
  always_ff @(posedge clk) begin
    if (rstn) begin
      blk_q       <= '0;
      base_q      <= '0;
      last_q      <= 1'b0;
      lambda_q    <= '0;
      half_q      <= 1'b0;
      min_q       <= '0;
      best_q      <= '0;
      expect_q    <= '0;
      best_cost_o <= '0;
      err_o       <= 1'b0;
    end else begin
      if (accept && !cand_ok) begin
        err_o <= 1'b1;
      end
      if (match && (state_q == ST_IDLE)) begin
        blk_q    <= blk_idx_i;
        base_q   <= base_mv_i;
        last_q   <= last_blk_i;
        lambda_q <= lambda_i;
        half_q   <= half_flag_i;
        min_q    <= cand_cost;
        best_q   <= 4'd0;
        expect_q <= 4'd1;
      end
      if (match && (state_q == ST_ACC)) begin
        if (cand_cost < min_q) begin
          min_q  <= cand_cost;
          best_q <= cand_i;
        end
        expect_q <= expect_q + 4'd1;
      end
      if (state_q == ST_WRITE) begin
        best_cost_o <= min_q;
      end
    end
  end

  fme_mv_buf #(
    .DATA_WIDTH (2*FMV_WIDTH),
    .ADDR_WIDTH (6)
  ) u_mv_buf (
    .clk   (clk),
    .rstn  (rstn),
    .we    (buf_we),
    .waddr (blk_q),
    .wdata ({new_x, new_y}),
    .re    (mv_rden_i),
    .raddr (mv_rdaddr_i),
    .rdata (mv_data_o)
  );

endmodule

// File: tb/tb_fme_cost_cmp.sv
// Self-checking bench for fme_cost_cmp: a table of whole-block vectors with
// hand-computed winners, then directed sequences for pass completion,
// read-first collision, protocol errors and mid-block reset.
module tb_fme_cost_cmp;

  logic        clk = 1'b0;
  logic        rstn;
  logic        half_flag_i;
  logic [7:0]  lambda_i;
  logic        cost_valid_i;
  logic        cost_ready_o;
  logic [3:0]  cand_i;
  logic [15:0] satd_i;
  logic [5:0]  blk_idx_i;
  logic [19:0] base_mv_i;
  logic        last_blk_i;
  logic        mv_rden_i;
  logic [5:0]  mv_rdaddr_i;
  logic [19:0] mv_data_o;
  logic [19:0] best_cost_o;
  logic        cost_done_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic              half;
    logic [7:0]        lambda;
    logic signed [9:0] bx;
    logic signed [9:0] by;
    logic [5:0]        blk;
    logic [8:0][15:0]  satd;
    logic signed [9:0] ex;
    logic signed [9:0] ey;
    logic [19:0]       ecost;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  fme_cost_cmp dut (
    .clk          (clk),
    .rstn         (rstn),
    .half_flag_i  (half_flag_i),
    .lambda_i     (lambda_i),
    .cost_valid_i (cost_valid_i),
    .cost_ready_o (cost_ready_o),
    .cand_i       (cand_i),
    .satd_i       (satd_i),
    .blk_idx_i    (blk_idx_i),
    .base_mv_i    (base_mv_i),
    .last_blk_i   (last_blk_i),
    .mv_rden_i    (mv_rden_i),
    .mv_rdaddr_i  (mv_rdaddr_i),
    .mv_data_o    (mv_data_o),
    .best_cost_o  (best_cost_o),
    .cost_done_o  (cost_done_o),
    .err_o        (err_o)
  );

  function automatic logic [19:0] mvPack(input logic signed [9:0] x, input logic signed [9:0] y);
    return {x, y};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one candidate for one cycle; returns at the following negedge
  task automatic applyStimulus(input logic [3:0] c, input logic [15:0] s);
    cost_valid_i = 1'b1;
    cand_i       = c;
    satd_i       = s;
    @(negedge clk);
  endtask

  task automatic setMeta(input logic h, input logic [7:0] lam, input logic signed [9:0] bx,
                         input logic signed [9:0] by, input logic [5:0] blk, input logic last);
    half_flag_i = h;
    lambda_i    = lam;
    base_mv_i   = mvPack(bx, by);
    blk_idx_i   = blk;
    last_blk_i  = last;
  endtask

  // Scramble block context after candidate 0 so only the sampled copy counts
  task automatic scrambleMeta();
    half_flag_i = ~half_flag_i;
    lambda_i    = ~lambda_i;
    base_mv_i   = ~base_mv_i;
    blk_idx_i   = ~blk_idx_i;
    last_blk_i  = ~last_blk_i;
  endtask

  task automatic readMv(input logic [5:0] addr, input string name, input logic [19:0] exp);
    mv_rden_i   = 1'b1;
    mv_rdaddr_i = addr;
    @(negedge clk);
    mv_rden_i   = 1'b0;
    checkOutput(name, mv_data_o, exp);
  endtask

  task automatic runVector(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    setMeta(v.half, v.lambda, v.bx, v.by, v.blk, 1'b0);
    applyStimulus(4'd0, v.satd[0]);
    scrambleMeta();
    for (int c = 1; c < 9; c++) begin
      applyStimulus(c[3:0], v.satd[c]);
    end
    cost_valid_i = 1'b0;
    checkOutput({tag, "_ready_write"}, cost_ready_o, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_done"}, cost_done_o, 1'b0);
    checkOutput({tag, "_ready_idle"}, cost_ready_o, 1'b1);
    checkOutput({tag, "_cost"}, best_cost_o, v.ecost);
    readMv(v.blk, {tag, "_mv"}, mvPack(v.ex, v.ey));
    mv_rdaddr_i = v.blk + 6'd1;
    @(negedge clk);
    checkOutput({tag, "_mv_hold"}, mv_data_o, mvPack(v.ex, v.ey));
    checkOutput({tag, "_err"}, err_o, 1'b0);
  endtask

  initial begin
    rstn         = 1'b1;
    cost_valid_i = 1'b0;
    cand_i       = '0;
    satd_i       = '0;
    mv_rden_i    = 1'b0;
    mv_rdaddr_i  = '0;
    setMeta(1'b0, 8'd0, 10'sd0, 10'sd0, 6'd0, 1'b0);

    // Half pass, lambda 0: descending SATD, cand 8 wins, (8,-4)+(2,2)
    vecs[0] = '{half: 1'b1, lambda: 8'd0, bx: 10'sd8, by: -10'sd4, blk: 6'd5, satd: '0,
                ex: 10'sd10, ey: -10'sd2, ecost: 20'd20};
    for (int c = 0; c < 9; c++) vecs[0].satd[c] = 16'(100 - 10*c);
    // Quarter pass, lambda 4, flat SATD: centre wins
    vecs[1] = '{half: 1'b0, lambda: 8'd4, bx: 10'sd3, by: 10'sd7, blk: 6'd6, satd: '0,
                ex: 10'sd3, ey: 10'sd7, ecost: 20'd50};
    for (int c = 0; c < 9; c++) vecs[1].satd[c] = 16'd50;
    // Tie between cand 2 and cand 6: lower index kept
    vecs[2] = '{half: 1'b0, lambda: 8'd0, bx: 10'sd0, by: 10'sd0, blk: 6'd7, satd: '0,
                ex: 10'sd0, ey: -10'sd1, ecost: 20'd10};
    for (int c = 0; c < 9; c++) vecs[2].satd[c] = 16'd100;
    vecs[2].satd[2] = 16'd10;
    vecs[2].satd[6] = 16'd10;
    // Half pass, lambda 3: cand5 180+6=186, cand8 170+12=182 -> cand 8
    vecs[3] = '{half: 1'b1, lambda: 8'd3, bx: -10'sd2, by: 10'sd5, blk: 6'd12, satd: '0,
                ex: 10'sd0, ey: 10'sd7, ecost: 20'd182};
    for (int c = 0; c < 9; c++) vecs[3].satd[c] = 16'd250;
    vecs[3].satd[0] = 16'd200;
    vecs[3].satd[5] = 16'd180;
    vecs[3].satd[8] = 16'd170;
    // MV wrap: (511,-512)+(1,-1) -> (-512,511)
    vecs[4] = '{half: 1'b0, lambda: 8'd0, bx: 10'sd511, by: -10'sd512, blk: 6'd20, satd: '0,
                ex: -10'sd512, ey: 10'sd511, ecost: 20'd5};
    for (int c = 0; c < 9; c++) vecs[4].satd[c] = 16'd100;
    vecs[4].satd[3] = 16'd5;
    // Max lambda, max centre SATD: cand2 costs 255, first minimum
    vecs[5] = '{half: 1'b0, lambda: 8'd255, bx: 10'sd0, by: 10'sd0, blk: 6'd63, satd: '0,
                ex: 10'sd0, ey: -10'sd1, ecost: 20'd255};
    vecs[5].satd[0] = 16'hFFFF;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", cost_ready_o, 1'b0);
    checkOutput("rst_done", cost_done_o, 1'b0);
    checkOutput("rst_err", err_o, 1'b0);
    checkOutput("rst_cost", best_cost_o, 20'd0);
    checkOutput("rst_mvdata", mv_data_o, 20'd0);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready", cost_ready_o, 1'b1);

    for (int i = 0; i < 6; i++) begin
      runVector(vecs[i], i);
    end

    // Last block of pass on blk 63 with a read-first collision in WRITE
    $display("[TB] last-block and read-first sequence");
    setMeta(1'b0, 8'd0, 10'sd5, 10'sd5, 6'd63, 1'b1);
    for (int c = 0; c < 9; c++) begin
      applyStimulus(c[3:0], 16'd1);
    end
    cost_valid_i = 1'b0;
    last_blk_i   = 1'b0;
    checkOutput("last_ready_write", cost_ready_o, 1'b0);
    checkOutput("last_done_write", cost_done_o, 1'b0);
    mv_rden_i   = 1'b1;
    mv_rdaddr_i = 6'd63;
    @(negedge clk);
    mv_rden_i = 1'b0;
    checkOutput("last_done_pulse", cost_done_o, 1'b1);
    checkOutput("last_ready_done", cost_ready_o, 1'b0);
    checkOutput("read_first_old", mv_data_o, mvPack(10'sd0, -10'sd1));
    checkOutput("last_cost", best_cost_o, 20'd1);
    @(negedge clk);
    checkOutput("last_done_clear", cost_done_o, 1'b0);
    checkOutput("last_ready_back", cost_ready_o, 1'b1);
    readMv(6'd63, "read_first_new", mvPack(10'sd5, 10'sd5));

    // Out-of-order candidate: 0,1,3 then 2..8
    $display("[TB] protocol error sequence");
    setMeta(1'b0, 8'd0, 10'sd1, 10'sd1, 6'd40, 1'b0);
    applyStimulus(4'd0, 16'd50);
    applyStimulus(4'd1, 16'd40);
    applyStimulus(4'd3, 16'd1);
    checkOutput("err_set", err_o, 1'b1);
    checkOutput("err_ready", cost_ready_o, 1'b1);
    for (int c = 2; c < 9; c++) begin
      applyStimulus(c[3:0], (c == 7) ? 16'd30 : 16'd60);
    end
    cost_valid_i = 1'b0;
    checkOutput("err_ready_write", cost_ready_o, 1'b0);
    @(negedge clk);
    checkOutput("err_cost", best_cost_o, 20'd30);
    readMv(6'd40, "err_mv", mvPack(10'sd1, 10'sd2));
    checkOutput("err_sticky", err_o, 1'b1);

    // Reset after cand 4 of a block targeting blk 5: no write occurs
    $display("[TB] mid-block reset sequence");
    setMeta(1'b0, 8'd0, 10'sd0, 10'sd0, 6'd5, 1'b0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(c[3:0], (c == 1) ? 16'd1 : 16'd100);
    end
    cost_valid_i = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("mrst_ready", cost_ready_o, 1'b0);
    checkOutput("mrst_err", err_o, 1'b0);
    checkOutput("mrst_cost", best_cost_o, 20'd0);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    readMv(6'd5, "mrst_mv_kept", mvPack(10'sd10, -10'sd2));
    // A fresh block must start cleanly from IDLE
    setMeta(1'b1, 8'd1, 10'sd0, 10'sd0, 6'd50, 1'b0);
    for (int c = 0; c < 9; c++) begin
      applyStimulus(c[3:0], (c == 4) ? 16'd3 : 16'd9);
    end
    cost_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("mrst_next_err", err_o, 1'b0);
    checkOutput("mrst_next_cost", best_cost_o, 20'd5);
    readMv(6'd50, "mrst_next_mv", mvPack(-10'sd2, 10'sd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
